// File: rtl/float_pkg.sv
// Shared float field helpers and reducer state encoding.
// Helpers take zero-extended fields so any exponent/mantissa width up to 64 bits works.
package float_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    function automatic int word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic logic is_nan(input logic [63:0] exp_f, input logic [63:0] man_f,
                                    input int exp_w);
        logic [63:0] ones;
        ones = (64'd1 << exp_w) - 64'd1;
        return (exp_f == ones) && (man_f != 64'd0);
    endfunction

    function automatic logic is_zero(input logic [63:0] exp_f, input logic [63:0] man_f);
        return (exp_f == 64'd0) && (man_f == 64'd0);
    endfunction

endpackage

// File: rtl/float_cmp_param.sv
// Combinational sign-magnitude float compare: gt/eq are only asserted for ordered (non-NaN) pairs,
// with +0 and -0 treated as equal.
module float_cmp_param
    import float_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 gt,
    output logic                 eq,
    output logic                 a_nan,
    output logic                 b_nan
);

    logic a_zero;
    logic b_zero;
    logic ord_gt;
    logic [EXP_W+MAN_W-1:0] a_mag;
    logic [EXP_W+MAN_W-1:0] b_mag;

    assign a_mag = a[EXP_W+MAN_W-1:0];
    assign b_mag = b[EXP_W+MAN_W-1:0];

    always_comb begin
        a_nan  = is_nan(64'(a[EXP_W+MAN_W-1:MAN_W]), 64'(a[MAN_W-1:0]), EXP_W);
        b_nan  = is_nan(64'(b[EXP_W+MAN_W-1:MAN_W]), 64'(b[MAN_W-1:0]), EXP_W);
        a_zero = is_zero(64'(a[EXP_W+MAN_W-1:MAN_W]), 64'(a[MAN_W-1:0]));
        b_zero = is_zero(64'(b[EXP_W+MAN_W-1:MAN_W]), 64'(b[MAN_W-1:0]));
        eq     = !a_nan && !b_nan && ((a_zero && b_zero) || (a == b));
        // Negatives order inversely by magnitude; mixed signs are decided by sign once zeros are folded into eq.
        case ({a[EXP_W+MAN_W], b[EXP_W+MAN_W]})
            2'b00:   ord_gt = a_mag > b_mag;
            2'b11:   ord_gt = a_mag < b_mag;
            2'b01:   ord_gt = 1'b1;
            default: ord_gt = 1'b0;
        endcase
        gt = !a_nan && !b_nan && !eq && ord_gt;
    end

endmodule

// File: rtl/float_arg_reduce.sv
// Streaming arg-max/arg-min over a last-delimited packet; result is registered and held until
// out_ready, with in_ready low while the result waits.
module float_arg_reduce
    import float_pkg::*;
#(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int IDX_W    = 8,
    parameter int MODE_MIN = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_data,
    output logic [IDX_W-1:0]     out_index,
    output logic [IDX_W:0]       out_count,
    output logic                 out_nan,
    output logic                 out_overflow
);

    localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;

    logic [EXP_W+MAN_W:0] best;
    logic [IDX_W-1:0]     best_idx;
    logic [IDX_W:0]       count;
    logic                 nan_seen;
    logic                 ovf_seen;

    logic [EXP_W+MAN_W:0] cmp_a;
    logic [EXP_W+MAN_W:0] cmp_b;
    logic cmp_gt, cmp_eq, cmp_a_nan, cmp_b_nan;
    logic elem_nan, best_nan, elem_ovf, replace, accept;

    // Arg-min is arg-max with the operands swapped; the element's NaN flag follows its operand slot.
    assign cmp_a = (MODE_MIN != 0) ? best : in_data;
    assign cmp_b = (MODE_MIN != 0) ? in_data : best;

    float_cmp_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cmp (
        .a     (cmp_a),
        .b     (cmp_b),
        .gt    (cmp_gt),
        .eq    (cmp_eq),
        .a_nan (cmp_a_nan),
        .b_nan (cmp_b_nan)
    );

    assign elem_nan = (MODE_MIN != 0) ? cmp_b_nan : cmp_a_nan;
    assign best_nan = (MODE_MIN != 0) ? cmp_a_nan : cmp_b_nan;
    assign elem_ovf = count[IDX_W];
    assign replace  = !elem_nan && !elem_ovf && (best_nan || cmp_gt);
    assign accept   = in_valid && in_ready;

    assign in_ready     = (state != DONE);
    assign out_valid    = (state == DONE);
    assign out_data     = best;
    assign out_index    = best_idx;
    assign out_count    = count;
    assign out_nan      = nan_seen;
    assign out_overflow = ovf_seen;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? DONE : ACCUM;
            ACCUM:   if (accept && in_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            best     <= '0;
            best_idx <= '0;
            count    <= '0;
            nan_seen <= 1'b0;
            ovf_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    best     <= in_data;
                    best_idx <= '0;
                    count    <= CNT_ONE;
                    nan_seen <= elem_nan;
                    ovf_seen <= 1'b0;
                end
                ACCUM: if (accept) begin
                    if (replace) begin
                        best     <= in_data;
                        best_idx <= count[IDX_W-1:0];
                    end
                    if (!elem_ovf) count <= count + CNT_ONE;
                    nan_seen <= nan_seen | elem_nan;
                    ovf_seen <= ovf_seen | elem_ovf;
                end
                DONE: if (out_ready) begin
                    best     <= '0;
                    best_idx <= '0;
                    count    <= '0;
                    nan_seen <= 1'b0;
                    ovf_seen <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_arg_reduce.sv
// Scoreboard bench: three reducers (arg-max, arg-min, arg-max with 2-bit index) driven by directed packets.
module tb_float_arg_reduce;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [31:0] od   [3];
    logic [7:0]  oi   [3];
    logic [8:0]  oc   [3];
    logic        on   [3];
    logic        oo   [3];
    logic [31:0] id;
    logic        il;
    logic [1:0]  oi2;
    logic [2:0]  oc2;

    assign oi[2] = {6'd0, oi2};
    assign oc[2] = {6'd0, oc2};

    float_arg_reduce #(.MODE_MIN(0)) u_max (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id), .in_last(il),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_index(oi[0]),
        .out_count(oc[0]), .out_nan(on[0]), .out_overflow(oo[0]));

    float_arg_reduce #(.MODE_MIN(1)) u_min (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id), .in_last(il),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_index(oi[1]),
        .out_count(oc[1]), .out_nan(on[1]), .out_overflow(oo[1]));

    float_arg_reduce #(.IDX_W(2), .MODE_MIN(0)) u_small (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id), .in_last(il),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_index(oi2),
        .out_count(oc2), .out_nan(on[2]), .out_overflow(oo[2]));

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic [7:0]  idx;
        logic [8:0]  cnt;
        logic        nan;
        logic        ovf;
    } exp_t;

    exp_t        sbq [$];
    exp_t        e_mon;
    logic [31:0] pkt [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [31:0] data, input int idx, input int cnt,
                        input logic nan, input logic ovf);
        exp_t e;
        e.dut  = d;
        e.data = data;
        e.idx  = 8'(idx);
        e.cnt  = 9'(cnt);
        e.nan  = nan;
        e.ovf  = ovf;
        sbq.push_back(e);
    endtask

    task automatic send(input int d, input bit with_last);
        for (int i = 0; i < pkt.size(); i++) begin
            @(negedge clk);
            id    = pkt[i];
            il    = with_last && (i == pkt.size() - 1);
            iv[d] = 1'b1;
            chk("in_ready_accept", 64'(ir[d]), 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        iv[d] = 1'b0;
        il    = 1'b0;
        if (with_last) chk("out_valid_latency", 64'(ov[d]), 64'd1);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst && ov[d] && ordy[d]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 64'(d), 64'd99);
                end else begin
                    e_mon = sbq.pop_front();
                    chk("result_dut", 64'(d), 64'(e_mon.dut));
                    chk("out_data", 64'(od[d]), 64'(e_mon.data));
                    chk("out_index", 64'(oi[d]), 64'(e_mon.idx));
                    chk("out_count", 64'(oc[d]), 64'(e_mon.cnt));
                    chk("out_nan", 64'(on[d]), 64'(e_mon.nan));
                    chk("out_overflow", 64'(oo[d]), 64'(e_mon.ovf));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        id  = '0;
        il  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_out_valid", 64'(ov[d]), 64'd0);
            chk("reset_out_data", 64'(od[d]), 64'd0);
            chk("reset_out_index", 64'(oi[d]), 64'd0);
            chk("reset_out_count", 64'(oc[d]), 64'd0);
            chk("reset_out_nan", 64'(on[d]), 64'd0);
            chk("reset_out_overflow", 64'(oo[d]), 64'd0);
            chk("reset_in_ready", 64'(ir[d]), 64'd1);
        end

        // 1.0, -3.0, 2.0 -> max 2.0
        pkt = '{32'h3F800000, 32'hC0400000, 32'h40000000};
        push(0, 32'h40000000, 2, 3, 1'b0, 1'b0);
        send(0, 1'b1);

        // -0 then +0 compare equal: earliest kept
        pkt = '{32'h80000000, 32'h00000000};
        push(0, 32'h80000000, 0, 2, 1'b0, 1'b0);
        send(0, 1'b1);

        // NaN best replaced by first ordered value; later NaN ignored
        pkt = '{32'h7FC00000, 32'hC0400000, 32'h7FC00001};
        push(0, 32'hC0400000, 1, 3, 1'b1, 1'b0);
        send(0, 1'b1);

        // all-NaN packet keeps first NaN
        pkt = '{32'h7FC00000, 32'h7F800001};
        push(0, 32'h7FC00000, 0, 2, 1'b1, 1'b0);
        send(0, 1'b1);

        // -inf then +inf
        pkt = '{32'hFF800000, 32'h7F800000};
        push(0, 32'h7F800000, 1, 2, 1'b0, 1'b0);
        send(0, 1'b1);

        // backpressure: -1.0, 0.5 -> 0.5 at index 1, held while out_ready low
        @(posedge clk);
        #1 ordy[0] = 1'b0;
        pkt = '{32'hBF800000, 32'h3F000000};
        push(0, 32'h3F000000, 1, 2, 1'b0, 1'b0);
        send(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            id    = $urandom;
            il    = 1'($urandom_range(0, 1));
            iv[0] = 1'b1;
            @(negedge clk);
            chk("stall_in_ready", 64'(ir[0]), 64'd0);
            chk("stall_out_valid", 64'(ov[0]), 64'd1);
            chk("stall_out_data", 64'(od[0]), 64'h3F000000);
            chk("stall_out_index", 64'(oi[0]), 64'd1);
            chk("stall_out_count", 64'(oc[0]), 64'd2);
        end
        @(posedge clk);
        #1;
        iv[0]   = 1'b0;
        il      = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        pkt = '{32'h3F800000};
        push(0, 32'h3F800000, 0, 1, 1'b0, 1'b0);
        send(0, 1'b1);

        // arg-min: +inf, -inf, 1.0 -> -inf
        pkt = '{32'h7F800000, 32'hFF800000, 32'h3F800000};
        push(1, 32'hFF800000, 1, 3, 1'b0, 1'b0);
        send(1, 1'b1);

        // arg-min tie keeps earliest
        pkt = '{32'h40000000, 32'h3F800000, 32'h3F800000};
        push(1, 32'h3F800000, 1, 3, 1'b0, 1'b0);
        send(1, 1'b1);

        // 2-bit index: larger value at index 5 is past the indexable range
        pkt = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                32'h3F800000, 32'h41000000};
        push(2, 32'h3F800000, 0, 4, 1'b0, 1'b1);
        send(2, 1'b1);

        // reset mid-packet discards partial result
        pkt = '{32'h3F800000, 32'h40400000};
        send(2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(ir[2]), 64'd1);
        chk("midrst_out_valid", 64'(ov[2]), 64'd0);
        chk("midrst_out_count", 64'(oc[2]), 64'd0);
        pkt = '{32'h40000000};
        push(2, 32'h40000000, 0, 1, 1'b0, 1'b0);
        send(2, 1'b1);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
